segment_chase_engine: RTL and testbench

//  Parametrised multi-digit seven-segment "chase" animator. It steps a lit

---
 rtl/segment_chase_if.sv | 19 +
 rtl/segment_chase_engine.sv | 130 +++++++++++++
 tb/tb_segment_chase_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/segment_chase_if.sv
// Control and display bus for the segment chase engine.
// The master drives the animation controls. The slave returns the segment, position and wrap outputs.
interface segment_chase_if #(
  parameter int unsigned N_DIGITS = 4
);
  localparam int unsigned L     = 7 * N_DIGITS;
  localparam int unsigned POS_W = $clog2(L);

  logic             en;
  logic             dir;
  logic [1:0]       mode;
  logic             restart;
  logic [L-1:0]     seg_o;
  logic [POS_W-1:0] pos_o;
  logic             wrap_o;

  modport master (output en, dir, mode, restart, input seg_o, pos_o, wrap_o);
  modport slave  (input en, dir, mode, restart, output seg_o, pos_o, wrap_o);
endinterface

// File: rtl/segment_chase_engine.sv
// Multi-digit seven-segment chase animator.
// It has a prescaled step rate and three modes: loop, bounce and fill.
module segment_chase_engine #(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  segment_chase_if.slave  bus
);

  localparam int unsigned L     = 7 * N_DIGITS;
  localparam int unsigned POS_W = $clog2(L);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(L - 1);
  localparam logic [POS_W-1:0] POS_PREV = POS_W'(L - 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_LOOP   = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_FILL   = 2'b10
  } mode_e;

  logic [POS_W-1:0] pos_q,  pos_d;
  logic [DIV_W-1:0] div_q,  div_d;
  mode_e            mode_q, mode_d;
  logic             bdir_q, bdir_d;
  logic             fdir_q, fdir_d;
  logic             wrap_q, wrap_d;

  logic             tick_c;
  mode_e            mode_in_c;
  logic             beff_c;
  logic [L-1:0]     lit_c;

  assign tick_c    = bus.en && (div_q == DIV_LAST);
  assign mode_in_c = (bus.mode == 2'b11) ? MODE_LOOP : mode_e'(bus.mode);
  // The bounce direction is seeded from dir until bounce mode takes hold.
  assign beff_c    = (mode_q == MODE_BOUNCE) ? bdir_q : bus.dir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q  <= '0;
      div_q  <= '0;
      mode_q <= MODE_LOOP;
      bdir_q <= 1'b0;
      fdir_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      bdir_q <= bdir_d;
      fdir_q <= fdir_d;
      wrap_q <= wrap_d;
    end
  end

  // Next-state logic. A restart overrides a tick.
  always_comb begin
    pos_d  = pos_q;
    div_d  = div_q;
    mode_d = mode_q;
    bdir_d = bdir_q;
    fdir_d = fdir_q;
    wrap_d = 1'b0;

    if (mode_q != MODE_BOUNCE) bdir_d = bus.dir;
    if (bus.en) div_d = tick_c ? '0 : div_q + DIV_W'(1);

    if (bus.restart) begin
      pos_d  = '0;
      div_d  = '0;
      bdir_d = bus.dir;
      fdir_d = bus.dir;
      mode_d = mode_in_c;
    end else if (tick_c) begin
      mode_d = mode_in_c;
      if (mode_in_c == MODE_BOUNCE) begin
        if (!beff_c) begin
          if (pos_q == POS_LAST) begin
            pos_d  = POS_PREV;
            bdir_d = 1'b1;
            wrap_d = 1'b1;
          end else begin
            pos_d  = pos_q + POS_W'(1);
            bdir_d = 1'b0;
          end
        end else begin
          if (pos_q == '0) begin
            pos_d  = POS_W'(1);
            bdir_d = 1'b0;
            wrap_d = 1'b1;
          end else begin
            pos_d  = pos_q - POS_W'(1);
            bdir_d = 1'b1;
          end
        end
      end else begin
        fdir_d = bus.dir;
        if (!bus.dir) begin
          wrap_d = (pos_q == POS_LAST);
          pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else begin
          wrap_d = (pos_q == '0);
          pos_d  = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
        end
      end
    end
  end

  // Fill lights the span behind the head in the direction latched at the last tick.
  always_comb begin
    lit_c = '0;
    for (int unsigned i = 0; i < L; i++) begin
      if (mode_q == MODE_FILL)
        lit_c[i] = fdir_q ? (POS_W'(i) >= pos_q) : (POS_W'(i) <= pos_q);
      else
        lit_c[i] = (POS_W'(i) == pos_q);
    end
  end

  assign bus.seg_o  = ACTIVE_LOW ? ~lit_c : lit_c;
  assign bus.pos_o  = pos_q;
  assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_segment_chase_engine.sv
// Scoreboard bench for segment_chase_engine.
// It drives three instances: N=1/CLK_DIV=1, N=2/CLK_DIV=1 and N=1/CLK_DIV=4.
module tb_segment_chase_engine;

  logic clk;
  logic rst;

  segment_chase_if #(.N_DIGITS(1)) a_if ();
  segment_chase_if #(.N_DIGITS(2)) b_if ();
  segment_chase_if #(.N_DIGITS(1)) c_if ();

  segment_chase_engine #(.N_DIGITS(1), .CLK_DIV(1), .ACTIVE_LOW(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(a_if));
  segment_chase_engine #(.N_DIGITS(2), .CLK_DIV(1), .ACTIVE_LOW(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));
  segment_chase_engine #(.N_DIGITS(1), .CLK_DIV(4), .ACTIVE_LOW(1'b1))
    dut_c (.clk(clk), .rst(rst), .bus(c_if));

  typedef struct {
    int unsigned dut;
    string       name;
    logic [13:0] seg;
    logic [3:0]  pos;
    logic        wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned d, input string nm,
                          input logic [13:0] s, input int unsigned p, input logic w);
    exp_t e;
    e.dut  = d;
    e.name = nm;
    e.seg  = s;
    e.pos  = 4'(p);
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  function automatic logic [13:0] one7(input int unsigned p);
    logic [6:0] t;
    t = ~(7'd1 << p);
    return {7'h00, t};
  endfunction

  function automatic logic [13:0] one14(input int unsigned p);
    return ~(14'd1 << p);
  endfunction

  // Monitor: compares every queued expectation against the addressed DUT.
  exp_t        m_e;
  logic [13:0] m_seg;
  logic [3:0]  m_pos;
  logic        m_wrap;
  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      m_e = exp_q.pop_front();
      case (m_e.dut)
        0: begin m_seg = {7'h00, a_if.seg_o}; m_pos = 4'(a_if.pos_o); m_wrap = a_if.wrap_o; end
        1: begin m_seg = b_if.seg_o;          m_pos = b_if.pos_o;     m_wrap = b_if.wrap_o; end
        default: begin m_seg = {7'h00, c_if.seg_o}; m_pos = 4'(c_if.pos_o); m_wrap = c_if.wrap_o; end
      endcase
      checks++;
      if (m_seg !== m_e.seg || m_pos !== m_e.pos || m_wrap !== m_e.wrap) begin
        errors++;
        $display("FAIL %s @%0t: got seg=%b pos=%0d wrap=%b, expected seg=%b pos=%0d wrap=%b",
                 m_e.name, $time, m_seg, m_pos, m_wrap, m_e.seg, m_e.pos, m_e.wrap);
      end
    end
  end

  logic [6:0]  fill_up [7];
  int unsigned bseq    [27];

  initial begin
    fill_up = '{7'b1111110, 7'b1111100, 7'b1111000, 7'b1110000,
                7'b1100000, 7'b1000000, 7'b0000000};
    bseq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13,
             12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    rst = 1'b0;
    a_if.en = 1'b0; a_if.dir = 1'b0; a_if.mode = 2'b00; a_if.restart = 1'b0;
    b_if.en = 1'b0; b_if.dir = 1'b0; b_if.mode = 2'b00; b_if.restart = 1'b0;
    c_if.en = 1'b0; c_if.dir = 1'b0; c_if.mode = 2'b00; c_if.restart = 1'b0;

    // T1: reset values
    repeat (3) step();
    push_exp(0, "t1_reset_a", {7'h00, 7'b1111110}, 0, 1'b0);
    push_exp(1, "t1_reset_b", 14'b11111111111110, 0, 1'b0);
    push_exp(2, "t1_reset_c", {7'h00, 7'b1111110}, 0, 1'b0);
    rst = 1'b1;
    step();

    // T2: loop up, wrap at 6 -> 0
    a_if.en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      push_exp(0, "t2_loop_up", one7(k % 7), k % 7, k == 7);
    end
    a_if.en = 1'b0;

    // T3: loop down from 0
    a_if.dir = 1'b1;
    a_if.en  = 1'b1;
    step(); push_exp(0, "t3_down_wrap", one7(6), 6, 1'b1);
    step(); push_exp(0, "t3_down_5",    one7(5), 5, 1'b0);
    step(); push_exp(0, "t3_down_4",    one7(4), 4, 1'b0);
    a_if.en  = 1'b0;
    a_if.dir = 1'b0;

    // Restart while paused
    a_if.restart = 1'b1;
    step(); push_exp(0, "restart_paused", one7(0), 0, 1'b0);
    a_if.restart = 1'b0;

    // T5: fill up through a wrap
    a_if.mode = 2'b10;
    a_if.en   = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      push_exp(0, "t5_fill_up", {7'h00, fill_up[k % 7]}, k % 7, k == 7);
    end
    a_if.en = 1'b0;

    // Fill down, then a dir change while paused must not disturb the display
    a_if.dir = 1'b1;
    a_if.en  = 1'b1;
    step(); push_exp(0, "fill_down_wrap", {7'h00, 7'b0111111}, 6, 1'b1);
    step(); push_exp(0, "fill_down_5",    {7'h00, 7'b0011111}, 5, 1'b0);
    a_if.en  = 1'b0;
    a_if.dir = 1'b0;
    step(); push_exp(0, "fill_paused_dir", {7'h00, 7'b0011111}, 5, 1'b0);
    a_if.mode = 2'b00;

    // T4: bounce over 14 positions, dir toggles ignored
    b_if.mode = 2'b01;
    b_if.en   = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      if (k == 5)  b_if.dir = 1'b1;
      if (k == 18) b_if.dir = 1'b0;
      step();
      push_exp(1, "t4_bounce", one14(bseq[k-1]), bseq[k-1], (k == 14) || (k == 27));
    end
    b_if.en = 1'b0;

    // T6: CLK_DIV=4 stepping
    c_if.en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      push_exp(2, "t6_div4", one7(k / 4), k / 4, 1'b0);
    end
    c_if.en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      push_exp(2, "t6_pause_hold", one7(2), 2, 1'b0);
    end
    c_if.en = 1'b1;
    step(); push_exp(2, "t6_resume_div3", one7(2), 2, 1'b0);
    step(); push_exp(2, "t6_resume_tick", one7(3), 3, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      push_exp(2, "t6_run_to_5", one7(3 + ((k > 8) ? 2 : k / 4)), 3 + ((k > 8) ? 2 : k / 4), 1'b0);
    end
    c_if.restart = 1'b1;
    step(); push_exp(2, "t6_restart", one7(0), 0, 1'b0);
    c_if.restart = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      push_exp(2, "t6_div_cleared", one7(k / 4), k / 4, 1'b0);
    end
    c_if.en = 1'b0;

    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
